// File: rtl/queue_read_scheduler.sv
// queue_read_scheduler: longest-first read slot scheduler with round-robin tie-break; SCHED_STARVE_GUARD_EN adds an age-based starvation override.
module queue_read_scheduler #(
  parameter int QDEPTH = 6,
  parameter int AGE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [2:0]  count1,
  input  logic [2:0]  count2,
  input  logic [2:0]  count3,
  input  logic [2:0]  count4,
  input  logic [11:0] buffer1,
  input  logic [11:0] buffer2,
  input  logic [11:0] buffer3,
  input  logic [11:0] buffer4,
  output logic [3:0]  reading,
  output logic [1:0]  out_data,
  output logic [1:0]  out_src,
  output logic        out_valid,
  output logic        busy,
  output logic [15:0] served1,
  output logic [15:0] served2,
  output logic [15:0] served3,
  output logic [15:0] served4,
  output logic [15:0] empty_slots,
  output logic [15:0] missed_ticks
);
  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, SETTLE} state_t;
  state_t state;
  logic [3:0][2:0] cnt;
  logic [3:0][1:0] head;
  logic [3:0][15:0] served;
  logic [1:0] rr_ptr, win, k, data_q;
  logic [3:0] key, best;
  logic any;
`ifdef SCHED_STARVE_GUARD_EN
  localparam int AW = $clog2(AGE_LIMIT + 1);
  logic [3:0][AW-1:0] age;
`endif
  function automatic logic [2:0] clamp(input logic [2:0] c);
    return (c > 3'(QDEPTH)) ? 3'(QDEPTH) : c;
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return v + 16'(v != 16'hFFFF);
  endfunction
  assign head = {buffer4[11:10], buffer3[11:10], buffer2[11:10], buffer1[11:10]};
  assign {served4, served3, served2, served1} = served;
  assign out_data = (state == ISSUE) ? head[out_src] : data_q;
  assign any = |cnt;
  // Scanning from rr_ptr with a strict '>' makes the first maximal key in cyclic order win.
  always_comb begin
    win = '0;
    best = '0;
    k = '0;
    key = '0;
    for (int j = 0; j < 4; j++) begin
      k = rr_ptr + 2'(j);
`ifdef SCHED_STARVE_GUARD_EN
      key = (cnt[k] != '0 && age[k] == AW'(AGE_LIMIT)) ? 4'b1000 : {1'b0, cnt[k]};
`else
      key = {1'b0, cnt[k]};
`endif
      if (key > best) begin
        best = key;
        win = k;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      served <= '0;
      rr_ptr <= '0;
      data_q <= '0;
      reading <= '0;
      out_src <= '0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      empty_slots <= '0;
      missed_ticks <= '0;
`ifdef SCHED_STARVE_GUARD_EN
      age <= '0;
`endif
    end else begin
      if (tick && state != IDLE) missed_ticks <= sat_inc(missed_ticks);
      case (state)
        IDLE: if (tick) begin
          cnt <= {clamp(count4), clamp(count3), clamp(count2), clamp(count1)};
          busy <= 1'b1;
          state <= SELECT;
        end
        SELECT: if (!any) begin
          empty_slots <= sat_inc(empty_slots);
          busy <= 1'b0;
          state <= IDLE;
        end else begin
          reading <= 4'b0001 << win;
          out_valid <= 1'b1;
          out_src <= win;
          state <= ISSUE;
`ifdef SCHED_STARVE_GUARD_EN
          for (int i = 0; i < 4; i++)
            age[i] <= (2'(i) == win || cnt[i] == '0) ? '0 :
                      (age[i] == AW'(AGE_LIMIT)) ? age[i] : age[i] + AW'(1);
`endif
        end
        ISSUE: begin
          reading <= '0;
          out_valid <= 1'b0;
          data_q <= head[out_src];
          served[out_src] <= sat_inc(served[out_src]);
          rr_ptr <= out_src + 2'd1;
          state <= SETTLE;
        end
        default: begin
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_queue_read_scheduler.sv
// tb_queue_read_scheduler: directed and randomized slots checked against a transaction-level scheduler model.
module tb_queue_read_scheduler;
`ifdef SCHED_STARVE_GUARD_EN
  localparam int AL = 2;
`else
  localparam int AL = 8;
`endif
  logic clk = 0, rst = 1, tick = 0;
  logic [2:0] cnt_in[4];
  logic [11:0] buf_in[4];
  logic [3:0] reading;
  logic [1:0] out_data, out_src;
  logic out_valid, busy;
  logic [15:0] served1, served2, served3, served4, empty_slots, missed_ticks;
  int checks = 0, failures = 0;
  int m_rr, m_empty, m_missed;
  int m_served[4], m_age[4];

  queue_read_scheduler #(.QDEPTH(6), .AGE_LIMIT(AL)) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .count1(cnt_in[0]), .count2(cnt_in[1]), .count3(cnt_in[2]), .count4(cnt_in[3]),
    .buffer1(buf_in[0]), .buffer2(buf_in[1]), .buffer3(buf_in[2]), .buffer4(buf_in[3]),
    .reading(reading), .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .busy(busy), .served1(served1), .served2(served2), .served3(served3), .served4(served4),
    .empty_slots(empty_slots), .missed_ticks(missed_ticks)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] served_of(input int q);
    return q == 0 ? served1 : q == 1 ? served2 : q == 2 ? served3 : served4;
  endfunction

  function automatic void model_clear();
    m_rr = 0; m_empty = 0; m_missed = 0;
    for (int i = 0; i < 4; i++) begin
      m_served[i] = 0;
      m_age[i] = 0;
    end
  endfunction

  // Winner = longest queue (counts above 6 read as 6), or an aged queue when the guard is built in;
  // among candidates the first one met walking cyclically from the round-robin pointer.
  function automatic int pick();
    int c[4];
    int mx = 0;
    bit aged_any = 0;
    for (int i = 0; i < 4; i++) begin
      c[i] = cnt_in[i] > 6 ? 6 : int'(cnt_in[i]);
      if (c[i] > mx) mx = c[i];
`ifdef SCHED_STARVE_GUARD_EN
      if (c[i] > 0 && m_age[i] == AL) aged_any = 1;
`endif
    end
    for (int j = 0; j < 4; j++) begin
      int q = (m_rr + j) % 4;
      if (aged_any ? (c[q] > 0 && m_age[q] == AL) : (mx > 0 && c[q] == mx)) return q;
    end
    return -1;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, ".reading"}, reading, 0);
    check({tag, ".out_data"}, out_data, 0);
    check({tag, ".out_src"}, out_src, 0);
    check({tag, ".out_valid"}, out_valid, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".served1"}, served1, 0);
    check({tag, ".served2"}, served2, 0);
    check({tag, ".served3"}, served3, 0);
    check({tag, ".served4"}, served4, 0);
    check({tag, ".empty_slots"}, empty_slots, 0);
    check({tag, ".missed_ticks"}, missed_ticks, 0);
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    model_clear();
  endtask

  // Starts and ends on a falling edge with the DUT idle; exp_w = -2 defers to the model.
  task automatic run_slot(input bit miss, input bit shuffle, input int exp_w);
    int w, h;
    w = (exp_w == -2) ? pick() : exp_w;
    tick = 1;
    @(negedge clk);
    tick = miss;
    if (miss) m_missed++;
    check("select.reading", reading, 0);
    check("select.busy", busy, 1);
    if (shuffle) for (int i = 0; i < 4; i++) buf_in[i] = 12'($urandom);
    @(negedge clk);
    tick = 0;
    if (w < 0) begin
      m_empty++;
      check("empty.reading", reading, 0);
      check("empty.out_valid", out_valid, 0);
      check("empty.busy", busy, 0);
      check("empty.empty_slots", empty_slots, m_empty);
      check("empty.missed_ticks", missed_ticks, m_missed);
      return;
    end
    h = int'(buf_in[w][11:10]);
    check("issue.reading", reading, 32'(1) << w);
    check("issue.out_valid", out_valid, 1);
    check("issue.out_src", out_src, w);
    check("issue.out_data", out_data, h);
    m_served[w]++;
    for (int i = 0; i < 4; i++)
      m_age[i] = (i == w || cnt_in[i] == 0) ? 0 : (m_age[i] + 1 > AL ? AL : m_age[i] + 1);
    m_rr = (w + 1) % 4;
    @(negedge clk);
    check("settle.reading", reading, 0);
    check("settle.out_valid", out_valid, 0);
    check("settle.busy", busy, 1);
    check("settle.out_data", out_data, h);
    if (shuffle) for (int i = 0; i < 4; i++) buf_in[i] = 12'($urandom);
    @(negedge clk);
    check("idle.busy", busy, 0);
    check("idle.out_data_hold", out_data, h);
    check("idle.served", served_of(w), m_served[w]);
    check("idle.missed_ticks", missed_ticks, m_missed);
  endtask

  task automatic set_counts(input int a, input int b, input int c, input int d);
    cnt_in[0] = 3'(a); cnt_in[1] = 3'(b); cnt_in[2] = 3'(c); cnt_in[3] = 3'(d);
  endtask

  initial begin
    set_counts(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) buf_in[i] = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 0;
    model_clear();

    run_slot(0, 0, -1);

    set_counts(2, 5, 1, 5);
    buf_in[1] = 12'b10_0000000000;
    run_slot(0, 0, 1);
    check("longest.out_data", out_data, 2'b10);

    do_reset();
    set_counts(3, 3, 3, 3);
    for (int q = 0; q < 4; q++) run_slot(0, 0, q);
    run_slot(0, 0, 0);

    do_reset();
    set_counts(1, 0, 0, 0);
    run_slot(1, 0, 0);
    check("missed.count", missed_ticks, 1);

    tick = 1;
    @(negedge clk);
    tick = 0;
    rst = 1;
    @(negedge clk);
    check_zero("midreset");
    rst = 0;
    model_clear();
    @(negedge clk);
    check("midreset.no_pulse", reading, 0);
    set_counts(0, 0, 4, 0);
    buf_in[2] = 12'b01_0000000000;
    run_slot(0, 0, 2);

    do_reset();
    set_counts(6, 0, 0, 1);
    run_slot(0, 0, 0);
    run_slot(0, 0, 0);
`ifdef SCHED_STARVE_GUARD_EN
    run_slot(0, 0, 3);
`else
    run_slot(0, 0, 0);
`endif

    do_reset();
    for (int n = 0; n < 120; n++) begin
      for (int i = 0; i < 4; i++)
        cnt_in[i] = ($urandom_range(0, 7) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) set_counts(0, 0, 0, 0);
      run_slot(1'($urandom_range(0, 3) == 0), 1, -2);
    end
    check("final.served1", served1, m_served[0]);
    check("final.served4", served4, m_served[3]);
    check("final.empty_slots", empty_slots, m_empty);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/queue_read_scheduler.md
# queue_read_scheduler

- Schedules reads from the four 2-bit-symbol queues maintained by the per-queue write/drop logic.
- On each display read slot, it chooses one non-empty queue, pulses that queue's `reading` line for one cycle and captures the head symbol for the VGA pixel path.
- It also keeps per-queue service statistics.
- It sits between the queue writer and the VGA renderer.

## Interface
Parameters:
- `QDEPTH`, 6: queue capacity in entries; a count equal to `QDEPTH` means the queue is full.
- `AGE_LIMIT`, 8: number of consecutive grants to other queues after which a non-empty queue is forced to win. Used only when the configuration macro is defined.

Ports:
- `clk`, in, 1: system clock; all logic is on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `tick`, in, 1: read-slot strobe, one cycle wide, from VGA timing.
- `count1`..`count4`, in, 3 each: occupancy of each queue, in entries.
- `buffer1`..`buffer4`, in, 12 each: queue storage; the head symbol is bits [11:10].
- `reading`, out, 4: one-hot dequeue pulse; bit k-1 serves queue k.
- `out_data`, out, 2: captured head symbol.
- `out_src`, out, 2: index of the served queue, 0..3.
- `out_valid`, out, 1: one-cycle qualifier for `out_data` and `out_src`.
- `busy`, out, 1: high whenever the state machine is not in IDLE.
- `served1`..`served4`, out, 16 each: grants per queue; saturate at 16'hFFFF.
- `empty_slots`, out, 16: ticks taken when every queue was empty; saturating.
- `missed_ticks`, out, 16: ticks that arrived while busy; saturating.

## Operation
- States: IDLE, SELECT, ISSUE, SETTLE. Reset enters IDLE.
- **IDLE:** when `tick`=1, register `count1..4` and go to SELECT.
- **SELECT:** compute the winner from the registered counts.
  - If all four counts are zero, increment `empty_slots` and return to IDLE.
  - Otherwise the winner is the queue with the largest count.
  - Ties go to the first tied queue at or after `rr_ptr`, cyclic order 0→1→2→3→0.
  - Then go to ISSUE.
- **ISSUE:** drive `reading[w]`=1 and `out_valid`=1 for this one cycle.
  - `out_data` = `buffer(w+1)[11:10]`, sampled live in this cycle.
  - `out_src` = w.
  - `served(w+1)` increments (saturating).
  - `rr_ptr` becomes (w+1) mod 4.
  - Go to SETTLE.
- **SETTLE:** one cycle that lets the writer's count update settle, then return to IDLE. No tick is accepted here.
- `tick` arriving in SELECT, ISSUE or SETTLE increments `missed_ticks` and is otherwise ignored. It is not queued.
- `reading` is zero in every state except ISSUE. At most one bit is ever set.
- `out_data` and `out_src` hold their last values outside ISSUE. Only `out_valid` qualifies them.
- Counts above `QDEPTH` are treated as `QDEPTH`: they are compared as equal to a full queue.
- All statistics counters stick at 16'hFFFF and do not wrap.
- Reset asserted in any state:
  - state goes to IDLE;
  - `rr_ptr`=0;
  - all outputs go to 0 on the next edge;
  - an ISSUE cut short by reset does not produce its `reading` pulse.

## Timing
- Minimum latency is 2 cycles: `tick` sampled at edge T, SELECT during T+1, and `reading` and `out_valid` high during T+2.
- For an empty slot, `empty_slots` updates at edge T+2 and the block is back in IDLE.
- Slot occupancy is 4 cycles when granted and 2 cycles when empty. The maximum accepted tick rate is one per 4 cycles.
- `busy` is registered and high from the cycle after `tick` through the SETTLE cycle.
- Reset values: `reading`=0, `out_data`=0, `out_src`=0, `out_valid`=0, `busy`=0, and all counters = 0.

## Configuration
- Macro: `SCHED_STARVE_GUARD_EN`.
- **Defined:**
  - Each queue has an age counter, `$clog2(AGE_LIMIT+1)` bits wide.
  - On every grant, the age counter of each non-winning non-empty queue increments, saturating at `AGE_LIMIT`.
  - The winner's age counter and those of empty queues clear to 0.
  - In SELECT, any non-empty queue with age == `AGE_LIMIT` overrides longest-first.
  - If several queues are aged, the round-robin rule picks among them.
  - Age counters reset to 0.
- **Undefined:**
  - No age logic is generated.
  - Selection is purely longest-first with round-robin tie-break.

## Test plan
- **Empty:** reset, all counts 0, one `tick` → `reading` stays 0, `out_valid` stays 0, `empty_slots`=1 after 2 cycles.
- **Longest-first:**
  - Stimulus: counts 2,5,1,5, `buffer2[11:10]`=2'b10, `tick` at cycle 0.
  - Expected: `reading`=4'b0010 at cycle 2; `out_data`=2'b10; `out_src`=1; `served2`=1.
- **Round-robin tie:**
  - Stimulus: all counts held at 3, four ticks spaced 4 cycles apart.
  - Expected: grants to queues 0,1,2,3 in order, one pulse each; `rr_ptr` back to 0.
- **Missed tick:** `tick` at cycles 0 and 2, count1=1 → one grant only, `missed_ticks`=1.
- **Mid-slot reset:**
  - Stimulus: `rst` asserted during SELECT.
  - Expected: no `reading` pulse; all outputs 0 the next cycle.
  - Follow-up: a later tick with count3=4 is served normally.
- **Starvation guard** (`SCHED_STARVE_GUARD_EN` defined, `AGE_LIMIT`=2):
  - Stimulus: count1=6 held and count4=1 held, ticks every 4 cycles.
  - Expected: grants queue0, queue0, then queue3 on the third tick.
  - Without the macro: every grant goes to queue0.
